// File: rtl/x161_divn_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : x161_divn_ctrl_pkg                                      |
// | Purpose : Shared types, N-encoding constants and small helpers    |
// |           for the x74161 divide-by-N sequencer.                   |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package x161_divn_ctrl_pkg;

  // Controller state encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // N input encoding: 0 stands for 16, 1 is clamped up to the minimum modulus
  localparam int N_ZERO_MEANS = 16;
  localparam int N_MIN        = 2;

  // Effective modulus (2..16) for a raw 4-bit N request
  function automatic logic [4:0] n_eff(input logic [3:0] n);
    logic [4:0] r;
    if (n == 4'd0) begin
      r = 5'(N_ZERO_MEANS);
    end else if (n == 4'd1) begin
      r = 5'(N_MIN);
    end else begin
      r = {1'b0, n};
    end
    return r;
  endfunction

  // Preset that makes a 4-bit up-counter reach 15 after n_lat-1 increments
  function automatic logic [3:0] preset_of(input logic [4:0] n_lat);
    logic [4:0] diff;
    diff = 5'd16 - n_lat;
    return diff[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/x161_divn_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : x161_divn_ctrl_if                                       |
// | Purpose : Control inputs, counter feedback and counter/downstream |
// |           outputs of the divide-by-N sequencer.                   |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
interface x161_divn_ctrl_if #(
  parameter int WRAP_W = 8
);
  // Control and counter feedback (into the sequencer)
  logic              START;
  logic              STOP;
  logic              EN;
  logic [3:0]        N;
  logic [3:0]        Q;
  logic              TC;
  // Counter control and downstream results (out of the sequencer)
  logic              PE;
  logic [3:0]        D;
  logic              CEP;
  logic              CET;
  logic              DIV_OUT;
  logic [WRAP_W-1:0] WRAPS;
  logic              OVF;

  // Environment side: system control plus the x74161 feedback
  modport master (
    output START, STOP, EN, N, Q, TC,
    input  PE, D, CEP, CET, DIV_OUT, WRAPS, OVF
  );

  // Sequencer side
  modport slave (
    input  START, STOP, EN, N, Q, TC,
    output PE, D, CEP, CET, DIV_OUT, WRAPS, OVF
  );
endinterface
`default_nettype wire

// File: rtl/x161_divn_ctrl_sat_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : x_sat_cnt                                               |
// | Purpose : Saturating event counter with sticky overflow flag and  |
// |           synchronous clear.                                      |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module x_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  logic full;
  assign full = &cnt;

  // Count events, hold at all-ones, and flag any event that arrives while full
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (full) begin
        ovf <= 1'b1;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/x161_divn_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : x161_divn_ctrl                                          |
// | Purpose : Divide-by-N sequencer for an adjacent x74161 counter.   |
// |           Presets the counter to 16-N so TC marks every Nth       |
// |           cycle, and reports the divided pulse and wrap count.    |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module x161_divn_ctrl
  import x161_divn_ctrl_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic             CP,
  input  logic             CR,
  x161_divn_ctrl_if.slave  bus
);

  state_t     state;
  state_t     state_nx;
  logic [4:0] n_lat;
  logic       wrap;
  logic       start_ld;

  // A wrap is the RUN cycle in which the counter sits at terminal count
  assign wrap     = (state == ST_RUN) && bus.TC;
  // IDLE -> LOAD edge; STOP outranks START
  assign start_ld = (state == ST_IDLE) && !bus.STOP && bus.START;

  // State register
  always_ff @(posedge CP) begin
    if (CR) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: STOP wins over every other request
  always_comb begin
    state_nx = state;
    if (bus.STOP) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.START) state_nx = ST_LOAD;
        ST_LOAD: state_nx = bus.EN ? ST_RUN : ST_HOLD;
        ST_RUN:  if (!bus.EN) state_nx = ST_HOLD;
        ST_HOLD: if (bus.EN) state_nx = ST_RUN;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Modulus is sampled only at start and at each wrap, so a new N applies
  // from the period after the next reload
  always_ff @(posedge CP) begin
    if (CR) begin
      n_lat <= 5'd16;
    end else if (start_ld || wrap) begin
      n_lat <= n_eff(bus.N);
    end
  end

  // Counter control: load in LOAD, count in RUN with reload at TC, freeze in HOLD
  always_comb begin
    bus.PE  = 1'b1;
    bus.CEP = 1'b0;
    bus.CET = 1'b0;
    case (state)
      ST_LOAD: bus.PE = 1'b0;
      ST_RUN: begin
        bus.PE  = ~bus.TC;
        bus.CEP = 1'b1;
        bus.CET = 1'b1;
      end
      ST_HOLD: bus.CET = 1'b1;
      default: bus.PE = 1'b1;
    endcase
  end

  assign bus.D       = preset_of(n_lat);
  assign bus.DIV_OUT = wrap;

  // Wrap statistics survive STOP; only reset and a fresh START clear them
  x_sat_cnt #(
    .WIDTH (WRAP_W)
  ) u_wraps (
    .clk (CP),
    .rst (CR),
    .clr (start_ld),
    .inc (wrap),
    .cnt (bus.WRAPS),
    .ovf (bus.OVF)
  );

endmodule
`default_nettype wire
